snake_game_engine: RTL

//  Parametrised snake game core: grid-cell snake of up to MAX_LEN segments, button steering,

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_food_gen.sv | 31 +++
 rtl/snake_game_engine.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state types, colours and helpers for the snake core
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [11:0] COL_OFF    = 12'h000;
  localparam logic [11:0] COL_HEAD   = 12'h0F0;
  localparam logic [11:0] COL_BODY   = 12'h00F;
  localparam logic [11:0] COL_FOOD   = 12'hF00;
  localparam logic [11:0] COL_BORDER = 12'h888;
  localparam logic [11:0] COL_GRID   = 12'h111;
  localparam logic [11:0] COL_DEAD   = 12'hF0F;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_food_gen.sv
// rtl/snake_food_gen.sv - free-running 16-bit Galois LFSR and food candidate cell mapping
module snake_food_gen
  import snake_pkg::*;
#(
  parameter int          GRID_W    = 64,
  parameter int          GRID_H    = 48,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          XW        = $clog2(GRID_W),
  parameter int          YW        = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [XW-1:0] cand_x,
  output logic [YW-1:0] cand_y
);

  logic [15:0] lfsr;

  // Keeps running across game restarts so successive games see different food
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign cand_x = XW'(lfsr % 16'(GRID_W));
  assign cand_y = YW'({8'h00, lfsr[15:8]} % 16'(GRID_H));

endmodule

// File: rtl/snake_game_engine.sv
// rtl/snake_game_engine.sv - snake game core: steering, movement, growth, collision, food, pixel colour
// Define SNAKE_WRAP_EN to make the playfield edges wrap instead of killing the snake.
module snake_game_engine
  import snake_pkg::*;
#(
  parameter int          CELL_PX   = 10,
  parameter int          GRID_W    = 64,
  parameter int          GRID_H    = 48,
  parameter int          MAX_LEN   = 32,
  parameter int          START_LEN = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     move_tick,
  input  logic                     start,
  input  logic [3:0]               btn_dir,
  input  logic                     bright,
  input  logic [9:0]               hCount,
  input  logic [9:0]               vCount,
  output logic [11:0]              rgb,
  output logic [15:0]              score,
  output logic [$clog2(MAX_LEN):0] length,
  output logic                     game_over
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN) + 1;

  state_t        state, next_state;
  dir_t          dir, pending_dir, req_dir, ref_dir;
  logic          req_valid;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [XW-1:0] food_x, next_x, cand_x;
  logic [YW-1:0] food_y, next_y, cand_y;
  logic          food_valid;
  logic          do_move, reinit;
  logic          wall_hit, self_hit, collide, eat, grow, occupied;
  int            nx, ny;

  logic [9:0]    pix_cx, pix_cy, pix_mx, pix_my;
  logic          in_field, on_head, on_body, on_food;
  logic [11:0]   head_col, body_col;

  snake_food_gen #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .LFSR_SEED(LFSR_SEED),
    .XW       (XW),
    .YW       (YW)
  ) u_food_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .cand_x(cand_x),
    .cand_y(cand_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_move    = 1'b0;
    reinit     = 1'b0;
    case (state)
      IDLE, DEAD: begin
        if (start) begin
          next_state = RUN;
          reinit     = 1'b1;
        end
      end
      RUN: begin
        if (move_tick) begin
          do_move = 1'b1;
          if (collide) next_state = DEAD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign game_over = (state == DEAD);

  // A reversal is judged against the move being executed this cycle, if any
  always_comb begin
    req_valid = |btn_dir;
    req_dir   = RIGHT;
    if (btn_dir[3])      req_dir = UP;
    else if (btn_dir[2]) req_dir = DOWN;
    else if (btn_dir[1]) req_dir = LEFT;
    ref_dir = do_move ? pending_dir : dir;
  end

  always_comb begin
    nx       = int'(seg_x[0]);
    ny       = int'(seg_y[0]);
    wall_hit = 1'b0;
    case (pending_dir)
      UP:      ny = ny - 1;
      DOWN:    ny = ny + 1;
      LEFT:    nx = nx - 1;
      default: nx = nx + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx < 0)            nx = GRID_W - 1;
    else if (nx >= GRID_W) nx = 0;
    if (ny < 0)            ny = GRID_H - 1;
    else if (ny >= GRID_H) ny = 0;
`else
    wall_hit = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
`endif
    next_x = XW'(nx);
    next_y = YW'(ny);
  end

  // The tail cell vacates on a plain move, so it only blocks when the snake grows into it
  always_comb begin
    eat      = food_valid && !wall_hit && (next_x == food_x) && (next_y == food_y);
    grow     = eat && (length < LW'(MAX_LEN));
    self_hit = 1'b0;
    occupied = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(length) - 1 || (eat && i == int'(length) - 1)) &&
          seg_x[i] == next_x && seg_y[i] == next_y)
        self_hit = 1'b1;
      if (i < int'(length) && seg_x[i] == cand_x && seg_y[i] == cand_y)
        occupied = 1'b1;
    end
    collide = wall_hit || self_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir         <= RIGHT;
      pending_dir <= RIGHT;
      score       <= '0;
      length      <= LW'(START_LEN);
      food_x      <= XW'(GRID_W / 4);
      food_y      <= YW'(GRID_H / 4);
      food_valid  <= 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(GRID_W / 2 - i);
        seg_y[i] <= YW'(GRID_H / 2);
      end
    end else if (reinit) begin
      dir         <= RIGHT;
      pending_dir <= RIGHT;
      score       <= '0;
      length      <= LW'(START_LEN);
      food_x      <= XW'(GRID_W / 4);
      food_y      <= YW'(GRID_H / 4);
      food_valid  <= 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(GRID_W / 2 - i);
        seg_y[i] <= YW'(GRID_H / 2);
      end
    end else begin
      if (req_valid && req_dir != opposite(ref_dir)) pending_dir <= req_dir;
      if (do_move && !collide) begin
        dir      <= pending_dir;
        seg_x[0] <= next_x;
        seg_y[0] <= next_y;
        for (int i = 1; i < MAX_LEN; i++) begin
          if (i < int'(length) || (grow && i == int'(length))) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
        end
        if (eat) begin
          if (score != 16'hFFFF) score <= score + 16'd1;
          if (grow) length <= length + 1'b1;
          food_valid <= 1'b0;
        end
      end
      // Placement waits out a move cycle so the candidate is checked against settled segments
      if (!food_valid && !do_move && !occupied) begin
        food_x     <= cand_x;
        food_y     <= cand_y;
        food_valid <= 1'b1;
      end
    end
  end

  assign pix_cx = hCount / 10'(CELL_PX);
  assign pix_cy = vCount / 10'(CELL_PX);
  assign pix_mx = hCount % 10'(CELL_PX);
  assign pix_my = vCount % 10'(CELL_PX);

  always_comb begin
    in_field = (hCount < 10'(GRID_W * CELL_PX)) && (vCount < 10'(GRID_H * CELL_PX));
    on_head  = in_field && pix_cx == 10'(seg_x[0]) && pix_cy == 10'(seg_y[0]);
    on_body  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i < int'(length) && in_field && pix_cx == 10'(seg_x[i]) && pix_cy == 10'(seg_y[i]))
        on_body = 1'b1;
    end
    on_food  = in_field && food_valid && pix_cx == 10'(food_x) && pix_cy == 10'(food_y);
    head_col = (state == DEAD) ? COL_DEAD : COL_HEAD;
    body_col = (state == DEAD) ? COL_DEAD : COL_BODY;
    if (!bright)                          rgb = COL_OFF;
    else if (on_head)                     rgb = head_col;
    else if (on_body)                     rgb = body_col;
    else if (on_food)                     rgb = COL_FOOD;
    else if (!in_field)                   rgb = COL_BORDER;
    else if (pix_mx == '0 || pix_my == '0) rgb = COL_GRID;
    else                                  rgb = COL_OFF;
  end

endmodule
